// File: rtl/elevator_shaft_model_if.sv
// elevator_shaft_model_if
//   Groups the controller-facing signals of the elevator shaft model.
//   master : the controller side (drives ac/open, observes the car).
//   slave  : the shaft model (consumes ac/open, reports car status).
//
//   ac        [1:0] motor command: 0 stop, 1 up, 2 down, 3 reserved (stop)
//   open            door-open request, level-sensitive
//   s         [3:0] one-hot floor sensor, 0 while between floors
//   floor     [1:0] last floor the car was aligned with
//   moving          car is between floors
//   door_open       door fully open
//   fault           sticky protocol-violation flag
//   dbg_state [2:0] current FSM state, for observation only
//
// Handshake: there is no valid/ready pair. The controller presents ac/open
// as levels that are sampled on every rising clk edge; the model presents
// registered status outputs that are valid every cycle once reset is released.
interface elevator_shaft_model_if;
    logic [1:0] ac;
    logic       open;
    logic [3:0] s;
    logic [1:0] floor;
    logic       moving;
    logic       door_open;
    logic       fault;
    logic [2:0] dbg_state;

    modport master (
        output ac, open,
        input  s, floor, moving, door_open, fault, dbg_state
    );

    modport slave (
        input  ac, open,
        output s, floor, moving, door_open, fault, dbg_state
    );
endinterface

// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model
//   Cycle-based model of a four-floor elevator car: travel between adjacent
//   floors takes FLOOR_TICKS cycles, door open/close takes DOOR_TICKS cycles.
//   Illegal commands (out-of-range motion, motion while the door is busy,
//   reversing mid-shaft) raise a sticky fault; once faulted, motion is
//   refused but the door keeps working.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : elevator_shaft_model_if.slave (ac, open in; s, floor, moving,
//            door_open, fault, dbg_state out; all outputs registered)
//
// Optional feature
//   ELEVATOR_SHAFT_DOOR_REOPEN_EN : when defined, open=1 during DOOR_CLOSING
//   reverses the door back to DOOR_OPENING. When undefined, closing always
//   completes and the door re-opens from AT_FLOOR.
module elevator_shaft_model #(
    parameter int FLOOR_TICKS = 16,
    parameter int DOOR_TICKS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    elevator_shaft_model_if.slave  bus
);

    typedef enum logic [2:0] {
        AT_FLOOR     = 3'd0,
        TRAVEL_UP    = 3'd1,
        TRAVEL_DOWN  = 3'd2,
        DOOR_OPENING = 3'd3,
        DOOR_OPEN    = 3'd4,
        DOOR_CLOSING = 3'd5
    } state_t;

    localparam logic [1:0] AC_UP   = 2'd1;
    localparam logic [1:0] AC_DOWN = 2'd2;
    localparam logic [7:0] FT_LOAD = 8'(FLOOR_TICKS - 1);
    localparam logic [7:0] DT_LOAD = 8'(DOOR_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] floor_q, floor_d;
    logic       fault_q, fault_d;
    logic [3:0] s_q, s_d;
    logic       moving_q, moving_d;
    logic       door_open_q, door_open_d;
    logic       motion_cmd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= AT_FLOOR;
            cnt_q       <= '0;
            floor_q     <= 2'd0;
            fault_q     <= 1'b0;
            s_q         <= 4'b0001;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            floor_q     <= floor_d;
            fault_q     <= fault_d;
            s_q         <= s_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        floor_d     = floor_q;
        fault_d     = fault_q;
        motion_cmd  = (bus.ac == AC_UP) || (bus.ac == AC_DOWN);

        case (state_q)
            AT_FLOOR: begin
                // open has priority; a motion command alongside it is illegal.
                if (bus.open) begin
                    if (motion_cmd) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = DOOR_OPENING;
                        cnt_d   = DT_LOAD;
                    end
                end else if (bus.ac == AC_UP) begin
                    if (floor_q == 2'd3) begin
                        fault_d = 1'b1;
                    end else if (!fault_q) begin
                        state_d = TRAVEL_UP;
                        cnt_d   = FT_LOAD;
                    end
                end else if (bus.ac == AC_DOWN) begin
                    if (floor_q == 2'd0) begin
                        fault_d = 1'b1;
                    end else if (!fault_q) begin
                        state_d = TRAVEL_DOWN;
                        cnt_d   = FT_LOAD;
                    end
                end
            end

            // The car cannot stop mid-shaft: stop/open are ignored and a
            // reverse command only flags a fault.
            TRAVEL_UP: begin
                if (bus.ac == AC_DOWN) fault_d = 1'b1;
                if (cnt_q == '0) begin
                    floor_d = floor_q + 2'd1;
                    state_d = AT_FLOOR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            TRAVEL_DOWN: begin
                if (bus.ac == AC_UP) fault_d = 1'b1;
                if (cnt_q == '0) begin
                    floor_d = floor_q - 2'd1;
                    state_d = AT_FLOOR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            DOOR_OPENING: begin
                if (motion_cmd) fault_d = 1'b1;
                if (!bus.open) begin
                    state_d = DOOR_CLOSING;
                    cnt_d   = DT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = DOOR_OPEN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            DOOR_OPEN: begin
                if (motion_cmd) fault_d = 1'b1;
                if (!bus.open) begin
                    state_d = DOOR_CLOSING;
                    cnt_d   = DT_LOAD;
                end
            end

            DOOR_CLOSING: begin
                if (motion_cmd) fault_d = 1'b1;
`ifdef ELEVATOR_SHAFT_DOOR_REOPEN_EN
                if (bus.open) begin
                    state_d = DOOR_OPENING;
                    cnt_d   = DT_LOAD;
                end else
`endif
                if (cnt_q == '0) begin
                    state_d = AT_FLOOR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = AT_FLOOR;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they are registered
        // yet line up with the state they describe.
        moving_d    = (state_d == TRAVEL_UP) || (state_d == TRAVEL_DOWN);
        s_d         = moving_d ? 4'b0000 : (4'b0001 << floor_d);
        door_open_d = (state_d == DOOR_OPEN);
    end

    assign bus.s         = s_q;
    assign bus.floor     = floor_q;
    assign bus.moving    = moving_q;
    assign bus.door_open = door_open_q;
    assign bus.fault     = fault_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
module tb_elevator_shaft_model;

  localparam int FT = 16;
  localparam int DT = 8;
  localparam int W  = 9;

  logic clk;
  logic reset;
  elevator_shaft_model_if bus();

  elevator_shaft_model #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: car position and door progress in whole cycles
  int m_floor;
  int m_travel_left;   // cycles of shaft travel remaining, 0 = parked
  int m_dir;           // +1 up, -1 down
  int m_door;          // 0 closed, 1 opening, 2 open, 3 closing
  int m_door_left;     // cycles until the current door movement completes
  bit m_fault;

  function automatic void model_reset();
    m_floor = 0; m_travel_left = 0; m_dir = 0;
    m_door = 0; m_door_left = 0; m_fault = 1'b0;
  endfunction

  function automatic void model_step(input logic [1:0] a, input logic o);
    bit motion;
    motion = (a == 2'd1) || (a == 2'd2);
    if (m_travel_left > 0) begin
      if ((m_dir > 0 && a == 2'd2) || (m_dir < 0 && a == 2'd1)) m_fault = 1'b1;
      m_travel_left--;
      if (m_travel_left == 0) m_floor += m_dir;
    end else if (m_door == 0) begin
      if (o) begin
        if (motion) m_fault = 1'b1;
        else begin m_door = 1; m_door_left = DT; end
      end else if (a == 2'd1) begin
        if (m_floor == 3) m_fault = 1'b1;
        else if (!m_fault) begin m_travel_left = FT; m_dir = 1; end
      end else if (a == 2'd2) begin
        if (m_floor == 0) m_fault = 1'b1;
        else if (!m_fault) begin m_travel_left = FT; m_dir = -1; end
      end
    end else begin
      if (motion) m_fault = 1'b1;
      if (m_door == 1) begin
        if (!o) begin m_door = 3; m_door_left = DT; end
        else begin
          m_door_left--;
          if (m_door_left == 0) m_door = 2;
        end
      end else if (m_door == 2) begin
        if (!o) begin m_door = 3; m_door_left = DT; end
      end else begin
`ifdef ELEVATOR_SHAFT_DOOR_REOPEN_EN
        if (o) begin m_door = 1; m_door_left = DT; end
        else begin
          m_door_left--;
          if (m_door_left == 0) m_door = 0;
        end
`else
        m_door_left--;
        if (m_door_left == 0) m_door = 0;
`endif
      end
    end
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [3:0] s;
    logic       mv;
    mv = (m_travel_left > 0);
    s  = mv ? 4'b0000 : 4'(1 << m_floor);
    return {s, 2'(m_floor), mv, (m_door == 2), m_fault};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {bus.s, bus.floor, bus.moving, bus.door_open, bus.fault};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got s=%b floor=%0d moving=%b door_open=%b fault=%b, expected s=%b floor=%0d moving=%b door_open=%b fault=%b",
               name, $time, act[8:5], act[4:3], act[2], act[1], act[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver tasks
  task automatic cycle(input logic [1:0] a, input logic o);
    @(negedge clk);
    reset  = 1'b1;
    bus.ac = a;
    bus.open = o;
    model_step(a, o);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.ac = 2'd0;
    bus.open = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_out(), model_out());
    exp_q.push_back(model_out());
    @(negedge clk);
    exp_q.push_back(model_out());
  endtask

  // monitor: one registered output vector per rising edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  // stimulus
  initial begin
    logic o_lvl;
    int r;
    logic [1:0] a;
    reset = 1'b0;
    bus.ac = 2'd0;
    bus.open = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_out(), {4'b0001, 2'd0, 1'b0, 1'b0, 1'b0});

    // one-floor trip up
    idle(2);
    cycle(2'd1, 1'b0);
    idle(FT + 2);

    // door held open 20 cycles, then released
    for (int i = 0; i < 20; i++) cycle(2'd0, 1'b1);
    idle(DT + 4);

    // climb to floor 3, then illegal up and a refused down
    cycle(2'd1, 1'b0); idle(FT + 1);
    cycle(2'd1, 1'b0); idle(FT + 1);
    cycle(2'd1, 1'b0); idle(3);
    cycle(2'd2, 1'b0); idle(FT + 2);

    // from floor 2 go down, reverse command mid-shaft
    do_reset();
    cycle(2'd1, 1'b0); idle(FT + 1);
    cycle(2'd1, 1'b0); idle(FT + 1);
    cycle(2'd2, 1'b0); idle(3);
    cycle(2'd1, 1'b0); idle(FT + 2);

    // door closing, open re-asserted after 3 cycles
    do_reset();
    for (int i = 0; i < DT + 3; i++) cycle(2'd0, 1'b1);
    cycle(2'd0, 1'b0);
    idle(3);
    for (int i = 0; i < 2 * DT + 6; i++) cycle(2'd0, 1'b1);
    idle(DT + 3);

    // motion command while door busy
    for (int i = 0; i < 4; i++) cycle(2'd0, 1'b1);
    cycle(2'd1, 1'b1);
    cycle(2'd2, 1'b1);
    idle(DT + 3);

    // reset mid-travel from floor 1
    do_reset();
    cycle(2'd1, 1'b0); idle(FT + 1);
    cycle(2'd1, 1'b0); idle(6);
    do_reset();
    idle(4);

    // randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      o_lvl = 1'b0;
      for (int i = 0; i < 250; i++) begin
        r = $urandom_range(0, 99);
        if (r < 6) o_lvl = ~o_lvl;
        r = $urandom_range(0, 99);
        if (r < 5) a = 2'd1;
        else if (r < 10) a = 2'd2;
        else if (r < 11) a = 2'd3;
        else a = 2'd0;
        if ($urandom_range(0, 299) == 0) do_reset();
        else cycle(a, o_lvl);
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_shaft_model.md
ELEVATOR_SHAFT_MODEL -- requirements
Module: elevator_shaft_model

Interface
REQ-001 Parameter FLOOR_TICKS, default 16, clk cycles to travel between adjacent floors (legal range 2..255).
REQ-002 Parameter DOOR_TICKS, default 8, clk cycles for door to fully open or fully close (legal range 2..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ac  input  2  motor command from controller: 0 stop, 1 up, 2 down, 3 reserved (treated as stop).
REQ-006 open  input  1  door-open request from controller, level-sensitive.
REQ-007 s  output  4  floor sensor, one-hot, bit n high only while car is aligned at floor n; 0 while between floors.
REQ-008 floor  output  2  last floor aligned with (0..3).
REQ-009 moving  output  1  high while car is between floors.
REQ-010 door_open  output  1  high only while door is fully open.
REQ-011 fault  output  1  sticky protocol-violation flag.

Function
REQ-012 FSM states SHALL be: AT_FLOOR, TRAVEL_UP, TRAVEL_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
REQ-013 AT_FLOOR: s=onehot(floor), moving=0, door_open=0; priority open > ac.
REQ-014 AT_FLOOR, open=1, ac=0: go DOOR_OPENING, tick counter loads DOOR_TICKS-1.
REQ-015 AT_FLOOR, open=0, ac=1, floor<3: go TRAVEL_UP, counter loads FLOOR_TICKS-1; s goes 0 next cycle.
REQ-016 AT_FLOOR, open=0, ac=2, floor>0: go TRAVEL_DOWN, counter loads FLOOR_TICKS-1.
REQ-017 ac=1 at floor 3, ac=2 at floor 0, or open=1 with ac in {1,2}: set fault, remain AT_FLOOR, no motion.
REQ-018 TRAVEL_*: counter decrements each cycle; at counter 0 floor increments (up) or decrements (down), state AT_FLOOR; s valid same cycle floor updates; total FLOOR_TICKS cycles with s=0.
REQ-019 TRAVEL_*: ac=0 or open=1 SHALL NOT stop the car mid-shaft; travel completes to next floor.
REQ-020 TRAVEL_UP with ac=2, or TRAVEL_DOWN with ac=1: set fault; travel still completes to next floor.
REQ-021 DOOR_OPENING: after DOOR_TICKS cycles go DOOR_OPEN; if open drops earlier go DOOR_CLOSING, counter loads DOOR_TICKS-1.
REQ-022 DOOR_OPEN: door_open=1; hold while open=1; open=0 go DOOR_CLOSING, counter loads DOOR_TICKS-1.
REQ-023 DOOR_CLOSING: after DOOR_TICKS cycles return AT_FLOOR.
REQ-024 Any door state with ac in {1,2}: set fault, command ignored, door sequence continues.
REQ-025 s SHALL remain onehot(floor) in all door states.
REQ-026 Once fault=1, motion commands SHALL be ignored (car stays at floor); door operation continues normally.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset low: state AT_FLOOR, floor=0, s=4'b0001, moving=0, door_open=0, fault=0, counter=0, immediately and asynchronously.
REQ-029 reset asserted mid-travel or mid-door SHALL abandon the operation; car re-initialises at floor 0.

Configuration
REQ-030 Macro ELEVATOR_SHAFT_DOOR_REOPEN_EN defined: open=1 in DOOR_CLOSING returns to DOOR_OPENING, counter loads DOOR_TICKS-1.
REQ-031 Macro undefined: open in DOOR_CLOSING is ignored; closing completes, AT_FLOOR then re-opens per REQ-014.

Verification
REQ-032 Reset, ac=1 one cycle then 0 -> s=0 for 16 cycles, then s=4'b0010, floor=1, moving=0.
REQ-033 At floor 1, open=1 held 20 cycles -> door_open=1 after 8 cycles; release -> door_open=0, AT_FLOOR 8 cycles later.
REQ-034 At floor 3, ac=1 -> fault=1, s stays 4'b1000; later ac=2 -> no motion.
REQ-035 At floor 2, ac=2 then ac=1 during travel -> fault=1, car arrives floor 1, s=4'b0010.
REQ-036 Door closing, open re-asserted after 3 cycles -> with macro: DOOR_OPENING, door_open=1 8 cycles later; without: AT_FLOOR after 5 more cycles, then reopen.
REQ-037 reset pulsed low at travel cycle 7 from floor 1 -> s=4'b0001, floor=0, moving=0 immediately.
